// File: rtl/counter_updown_scan.sv
// Up/down counter with wrap or saturate at a programmable terminal value, parallel load,
// and a registered terminal-count pulse. The count register also serves as a scan segment.
module counter_updown_scan #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // Next-state selection: scan > load > step > hold
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (scan_en) begin
      count_nxt = {count[WIDTH-2:0], scan_in};
    end else if (load) begin
      count_nxt = (load_val >= MAX_C) ? MAX_C : load_val;
    end else if (enable) begin
      if (up_down) begin
        // Out-of-range scanned values are treated as being at the top boundary
        if (count >= MAX_C) begin
          tc_nxt    = 1'b1;
          count_nxt = sat_mode ? MAX_C : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          tc_nxt    = 1'b1;
          count_nxt = sat_mode ? '0 : MAX_C;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  assign scan_out = count[WIDTH-1];
  assign at_max   = (count >= MAX_C);
  assign at_zero  = (count == '0);

endmodule

// File: tb/tb_counter_updown_scan.sv
// Directed bench for counter_updown_scan (WIDTH=4, MAX_VAL=9) with an expected-value queue
// filled at stimulus time and drained after each clock edge.
module tb_counter_updown_scan;

  localparam int unsigned W   = 4;
  localparam int unsigned MAX = 9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         scan_en, scan_in, scan_out;
  logic         enable, up_down, load, sat_mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, at_max, at_zero;

  logic [W:0]   exp_q[$];
  int           tests = 0;
  int           fails = 0;

  counter_updown_scan #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .enable   (enable),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .count    (count),
    .tc       (tc),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [W:0]   e;
    logic [W-1:0] ec;
    logic         et;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s queue: observed empty, expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ec = e[W:1];
      et = e[0];
      tests++;
      assert (count === ec) else begin
        fails++;
        $error("FAIL %s count: observed %0d expected %0d", tag, count, ec);
      end
      tests++;
      assert (tc === et) else begin
        fails++;
        $error("FAIL %s tc: observed %b expected %b", tag, tc, et);
      end
      tests++;
      assert (at_max === (32'(ec) >= MAX)) else begin
        fails++;
        $error("FAIL %s at_max: observed %b expected %b", tag, at_max, (32'(ec) >= MAX));
      end
      tests++;
      assert (at_zero === (ec == '0)) else begin
        fails++;
        $error("FAIL %s at_zero: observed %b expected %b", tag, at_zero, (ec == '0));
      end
      tests++;
      assert (scan_out === ec[W-1]) else begin
        fails++;
        $error("FAIL %s scan_out: observed %b expected %b", tag, scan_out, ec[W-1]);
      end
    end
  endtask

  // One clock edge: drive inputs, queue the expected result, compare just after the edge
  task automatic step(input string tag, input logic se, input logic si, input logic en,
                      input logic ud, input logic ld, input logic [W-1:0] lv,
                      input logic sm, input logic [W-1:0] ec, input logic et);
    scan_en  = se;
    scan_in  = si;
    enable   = en;
    up_down  = ud;
    load     = ld;
    load_val = lv;
    sat_mode = sm;
    exp_q.push_back({ec, et});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic shift1011(input string tag);
    step(tag, 1, 1, 0, 0, 0, 0, 0, 4'd1, 0);
    step(tag, 1, 0, 0, 0, 0, 0, 0, 4'd2, 0);
    step(tag, 1, 1, 0, 0, 0, 0, 0, 4'd5, 0);
    step(tag, 1, 1, 0, 0, 0, 0, 0, 4'd11, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    scan_en = 0; scan_in = 0; enable = 0; up_down = 1;
    load = 0; load_val = '0; sat_mode = 0;
    #12;
    exp_q.push_back({4'd0, 1'b0});
    check("reset");
    reset_n = 1'b1;

    // Up, wrap: 1..9 then 0 with tc
    for (int i = 1; i <= 9; i++) step("up_wrap", 0, 0, 1, 1, 0, 0, 0, W'(i), 0);
    step("up_wrap_tc", 0, 0, 1, 1, 0, 0, 0, 4'd0, 1);
    step("up_after_wrap", 0, 0, 1, 1, 0, 0, 0, 4'd1, 0);

    // Down, wrap: 0 -> 9 with tc, then down to 0; then saturate holds 0 with tc
    step("down", 0, 0, 1, 0, 0, 0, 0, 4'd0, 0);
    step("down_wrap_tc", 0, 0, 1, 0, 0, 0, 0, 4'd9, 1);
    for (int i = 8; i >= 0; i--) step("down", 0, 0, 1, 0, 0, 0, 0, W'(i), 0);
    for (int i = 0; i < 3; i++) step("down_sat_hold", 0, 0, 1, 0, 0, 0, 1, 4'd0, 1);

    // Load clamps and suppresses the step; enable=0 holds
    step("load_clamp", 0, 0, 1, 1, 1, 4'hC, 0, 4'd9, 0);
    step("load_3", 0, 0, 1, 1, 1, 4'd3, 0, 4'd3, 0);
    step("hold", 0, 0, 0, 1, 0, 0, 0, 4'd3, 0);

    // Scan an out-of-range value, then step up in wrap mode
    step("load_0", 0, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0);
    shift1011("scan");
    step("oor_up_wrap", 0, 0, 1, 1, 0, 0, 0, 4'd0, 1);

    // Same but saturate mode snaps to MAX
    step("load_0", 0, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0);
    shift1011("scan");
    step("oor_up_sat", 0, 0, 1, 1, 0, 0, 1, 4'd9, 1);
    step("up_sat_hold", 0, 0, 1, 1, 0, 0, 1, 4'd9, 1);
    step("sat_down", 0, 0, 1, 0, 0, 0, 1, 4'd8, 0);

    // Down from above MAX is an ordinary decrement
    step("load_0", 0, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0);
    shift1011("scan");
    step("oor_down", 0, 0, 1, 0, 0, 0, 0, 4'd10, 0);
    step("oor_down", 0, 0, 1, 0, 0, 0, 0, 4'd9, 0);

    // Scan overrides load and enable and clears tc
    step("up_sat_hold", 0, 0, 1, 1, 0, 0, 1, 4'd9, 1);
    step("scan_prio", 1, 1, 1, 1, 1, 4'd5, 1, 4'd3, 0);

    // Asynchronous reset between edges, then resume counting
    step("load_0", 0, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0);
    for (int i = 1; i <= 6; i++) step("pre_reset", 0, 0, 1, 1, 0, 0, 0, W'(i), 0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back({4'd0, 1'b0});
    check("async_reset");
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) step("post_reset", 0, 0, 1, 1, 0, 0, 0, W'(i), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_updown_scan.md
Name: counter_updown_scan

Overview:
- Parametrised successor to the basic 4-bit enable counter: programmable width and terminal value, up/down direction, synchronous parallel load, wrap or saturate mode, and a registered terminal-count pulse.
- The count register doubles as a serial scan segment: it shifts under scan_en so ATPG can control and observe the counter state.
- Used as a general event, timeout and address counter in the DFT-enabled datapath.

Parameters:
- WIDTH, 8, counter and load width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, terminal (highest functional) count value; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- scan_en  input  1  1 = scan shift mode; overrides all functional controls.
- scan_in  input  1  serial scan data in; shifts into count[0].
- scan_out  output  1  serial scan data out; equals count[WIDTH-1] combinationally.
- enable  input  1  count step enable.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate (hold) at boundaries.
- count  output  WIDTH  current count, registered.
- tc  output  1  registered terminal-count pulse.
- at_max  output  1  combinational, (count >= MAX_VAL).
- at_zero  output  1  combinational, (count == 0).

Behaviour:
- Reset: reset_n=0 asynchronously forces count=0 and tc=0. Outputs therefore read at_zero=1, at_max=0 (since MAX_VAL>=1), scan_out=0. Release is synchronous to the next clk edge; no other reset behaviour.
- Per-edge priority, highest first: scan_en > load > enable > hold.
- Scan (scan_en=1):
  - count <= {count[WIDTH-2:0], scan_in}; tc <= 0.
  - load, enable, up_down and sat_mode are ignored.
  - WIDTH edges fully replace the state. Shifted values may exceed MAX_VAL.
- Load (scan_en=0, load=1):
  - count <= min(load_val, MAX_VAL); tc <= 0.
  - enable is ignored in the same cycle, so there is no load+step.
- Count up (enable=1, up_down=1):
  - count < MAX_VAL: count+1.
  - count >= MAX_VAL: wrap mode gives 0; saturate mode gives MAX_VAL (an out-of-range scanned value snaps to MAX_VAL).
- Count down (enable=1, up_down=0):
  - count > MAX_VAL: count-1, no boundary event.
  - 0 < count <= MAX_VAL: count-1.
  - count == 0: wrap mode gives MAX_VAL; saturate mode holds 0.
- tc:
  - tc <= 1 on the edge that performs a boundary step: up from >= MAX_VAL or down from 0, in either mode. This includes saturated holds, so a counter parked at the boundary with enable high keeps tc high.
  - tc <= 0 on every other edge, including enable=0.
  - tc therefore lags the boundary step by 0 cycles relative to the new count value. It is asserted in the same cycle count shows the wrapped/held value.
- Arithmetic: unsigned, WIDTH bits; no intermediate overflow beyond WIDTH is observable.
- sat_mode and up_down are sampled every edge; changing them mid-count takes effect on the next step with no pipeline delay.
- Reset asserted mid-scan or mid-count: immediate clear, no partial-shift retention.

Test Plan:
- WIDTH=4, MAX_VAL=9, wrap, up, enable=1 from reset -> count 0,1,...,9,0; tc=1 only in the cycle count returns to 0; at_max=1 while count=9.
- Same config, down from 0 -> count 9,8,...; tc=1 in the cycle count=9 first appears; set sat_mode=1 at count=0 -> count holds 0, tc stays 1 each enabled cycle.
- load=1, load_val=4'hC with enable=1 -> count=9 (clamped), tc=0; then load_val=3 -> count=3 and no increment that cycle.
- scan_en=1, shift 1,0,1,1 over 4 edges from count=0 -> count=4'b1011 (11 > MAX_VAL), scan_out sequence follows count[3]; then scan_en=0, up, wrap -> count=0, tc=1; repeat with sat_mode=1 -> count=9.
- scan_en=1 together with load=1 and enable=1 -> only the shift occurs; count[0]=scan_in, tc=0.
- reset_n pulsed low mid-count at count=6 (asynchronous, between edges) -> count=0 and tc=0 immediately; counting resumes 1,2,... after release.
